idu: RTL and testbench

IDU -- requirements
Module: idu

---
 rtl/npc_pkg.sv | 65 ++++++
 rtl/imm_gen.sv | 36 +++
 rtl/idu.sv | 192 +++++++++++++++++++
 tb/tb_idu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// npc_pkg -- definitions shared by the decode stage (IDU) and the execute
// stage (EXU): RV64I major opcodes, the alu_op and has_funct encodings that
// travel in the decoded bundle, the immediate-format selector and the packed
// control part of the bundle.
package npc_pkg;

  // RV64I major opcodes (inst[6:0]) recognised by the decoder.
  localparam logic [6:0] OPC_LUI        = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
  localparam logic [6:0] OPC_JAL        = 7'b1101111;
  localparam logic [6:0] OPC_JALR       = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
  localparam logic [6:0] OPC_LOAD       = 7'b0000011;
  localparam logic [6:0] OPC_STORE      = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM     = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32  = 7'b0011011;
  localparam logic [6:0] OPC_OP         = 7'b0110011;
  localparam logic [6:0] OPC_OP_32      = 7'b0111011;

  // alu_op: operand class handed to the EXU.
  localparam logic [1:0] ALU_IMM    = 2'b00;  // OP-IMM, OP-IMM-32, store
  localparam logic [1:0] ALU_LOAD   = 2'b01;  // load
  localparam logic [1:0] ALU_REG    = 2'b10;  // OP, OP-32, LUI, AUIPC, JAL, JALR
  localparam logic [1:0] ALU_BRANCH = 2'b11;  // conditional branch

  // has_funct: which raw function fields the EXU must look at.
  localparam logic [1:0] HF_NONE  = 2'b00;    // U/J-type and JALR
  localparam logic [1:0] HF_F3    = 2'b01;    // funct3 only (I/S/B)
  localparam logic [1:0] HF_F3_F7 = 2'b11;    // funct3 and funct7 (R-type)

  // Immediate layout selector; FMT_R produces a zero immediate.
  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  // XLEN-independent part of the decoded bundle.
  typedef struct packed {
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [1:0] has_funct;
    logic       need_sext;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_wen;
    logic       mem_ren;
    logic       mem_wen;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  // Immediate shifts (SLLI/SRLI/SRAI and their W forms) carry their
  // arithmetic/logical selector in inst[31:25].
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen -- combinational RV64I immediate extraction.
//   inst_i : 32-bit instruction word
//   fmt_i  : immediate layout (I/S/B/U/J; R gives zero)
//   imm_o  : immediate, inst[31] replicated up to XLEN
module imm_gen
  import npc_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     inst_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic signed [31:0] imm32;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    imm32 = '0;
    unique case (fmt_i)
      FMT_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      FMT_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      FMT_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                      inst_i[30:25], inst_i[11:8], 1'b0};
      FMT_U: imm32 = {inst_i[31:12], 12'b0};
      FMT_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                      inst_i[20], inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Size cast of a signed value sign-extends to the full datapath width.
  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/idu.sv
// idu -- RV64I instruction decode unit with a single output register stage.
//   clk, rst           : clock, synchronous active-high reset
//   if_valid/if_ready  : handshake from fetch; if_inst/if_pc carry the word
//   flush              : drop the held bundle and any incoming instruction
//   id_valid/ex_ready  : handshake toward execute
//   alu_op, funct3, funct7, has_funct, need_sext, imm, rs1, rs2, rd,
//   reg_wen, mem_ren, mem_wen, branch, jump, illegal, id_pc : held bundle
module idu
  import npc_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic            id_valid,
  input  logic            ex_ready,
  output logic [1:0]      alu_op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [1:0]      has_funct,
  output logic            need_sext,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_wen,
  output logic            mem_ren,
  output logic            mem_wen,
  output logic            branch,
  output logic            jump,
  output logic            illegal,
  output logic [XLEN-1:0] id_pc
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic            state_q, state_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] imm_q, imm_d, pc_q;
  imm_fmt_e        fmt;
  logic            accept, load;
  logic [6:0]      opcode;

  assign opcode   = if_inst[6:0];
  assign id_valid = (state_q == ST_FULL);
  assign if_ready = !id_valid || ex_ready;
  assign accept   = if_valid && if_ready;
  assign load     = accept && !flush;

  // Decode: only fields the format uses are copied; the rest stay zero.
  always_comb begin
    ctrl_d = '0;
    fmt    = FMT_R;
    unique case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        ctrl_d.alu_op  = ALU_REG;
        ctrl_d.rd      = if_inst[11:7];
        ctrl_d.reg_wen = 1'b1;
        fmt            = FMT_U;
      end
      OPC_JAL: begin
        ctrl_d.alu_op  = ALU_REG;
        ctrl_d.rd      = if_inst[11:7];
        ctrl_d.reg_wen = 1'b1;
        ctrl_d.jump    = 1'b1;
        fmt            = FMT_J;
      end
      OPC_JALR: begin
        ctrl_d.alu_op  = ALU_REG;
        ctrl_d.rs1     = if_inst[19:15];
        ctrl_d.rd      = if_inst[11:7];
        ctrl_d.reg_wen = 1'b1;
        ctrl_d.jump    = 1'b1;
        fmt            = FMT_I;
      end
      OPC_BRANCH: begin
        ctrl_d.alu_op    = ALU_BRANCH;
        ctrl_d.has_funct = HF_F3;
        ctrl_d.funct3    = if_inst[14:12];
        ctrl_d.rs1       = if_inst[19:15];
        ctrl_d.rs2       = if_inst[24:20];
        ctrl_d.branch    = 1'b1;
        fmt              = FMT_B;
      end
      OPC_LOAD: begin
        ctrl_d.alu_op    = ALU_LOAD;
        ctrl_d.has_funct = HF_F3;
        ctrl_d.funct3    = if_inst[14:12];
        ctrl_d.rs1       = if_inst[19:15];
        ctrl_d.rd        = if_inst[11:7];
        ctrl_d.reg_wen   = 1'b1;
        ctrl_d.mem_ren   = 1'b1;
        fmt              = FMT_I;
      end
      OPC_STORE: begin
        ctrl_d.alu_op    = ALU_IMM;
        ctrl_d.has_funct = HF_F3;
        ctrl_d.funct3    = if_inst[14:12];
        ctrl_d.rs1       = if_inst[19:15];
        ctrl_d.rs2       = if_inst[24:20];
        ctrl_d.mem_wen   = 1'b1;
        fmt              = FMT_S;
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        ctrl_d.alu_op    = ALU_IMM;
        ctrl_d.has_funct = HF_F3;
        ctrl_d.funct3    = if_inst[14:12];
        ctrl_d.rs1       = if_inst[19:15];
        ctrl_d.rd        = if_inst[11:7];
        ctrl_d.reg_wen   = 1'b1;
        ctrl_d.need_sext = (opcode == OPC_OP_IMM_32);
        // Shift-immediates expose inst[31:25] so the EXU can tell SRAI from SRLI.
        if (is_shift_f3(if_inst[14:12])) ctrl_d.funct7 = if_inst[31:25];
        fmt              = FMT_I;
      end
      OPC_OP, OPC_OP_32: begin
        ctrl_d.alu_op    = ALU_REG;
        ctrl_d.has_funct = HF_F3_F7;
        ctrl_d.funct3    = if_inst[14:12];
        ctrl_d.funct7    = if_inst[31:25];
        ctrl_d.rs1       = if_inst[19:15];
        ctrl_d.rs2       = if_inst[24:20];
        ctrl_d.rd        = if_inst[11:7];
        ctrl_d.reg_wen   = 1'b1;
        ctrl_d.need_sext = (opcode == OPC_OP_32);
        fmt              = FMT_R;
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
    // Writes to x0 are architecturally discarded; suppress them here.
    if (ctrl_d.rd == 5'd0) ctrl_d.reg_wen = 1'b0;
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst_i (if_inst),
    .fmt_i  (fmt),
    .imm_o  (imm_d)
  );

  // Occupancy: flush wins over a same-cycle accept; otherwise a consumed
  // bundle empties the stage unless a new one is taken in.
  always_comb begin
    state_d = state_q;
    if (flush)         state_d = ST_EMPTY;
    else if (accept)   state_d = ST_FULL;
    else if (ex_ready) state_d = ST_EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  // The bundle registers are reset as well because reset must present an
  // all-zero bundle on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ctrl_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        ctrl_q <= ctrl_d;
        imm_q  <= imm_d;
        pc_q   <= if_pc;
      end
    end
  end

  assign alu_op    = ctrl_q.alu_op;
  assign funct3    = ctrl_q.funct3;
  assign funct7    = ctrl_q.funct7;
  assign has_funct = ctrl_q.has_funct;
  assign need_sext = ctrl_q.need_sext;
  assign rs1       = ctrl_q.rs1;
  assign rs2       = ctrl_q.rs2;
  assign rd        = ctrl_q.rd;
  assign reg_wen   = ctrl_q.reg_wen;
  assign mem_ren   = ctrl_q.mem_ren;
  assign mem_wen   = ctrl_q.mem_wen;
  assign branch    = ctrl_q.branch;
  assign jump      = ctrl_q.jump;
  assign illegal   = ctrl_q.illegal;
  assign imm       = imm_q;
  assign id_pc     = pc_q;

endmodule

// File: tb/tb_idu.sv
// tb_idu -- scoreboard bench for idu. The driver pushes a hand-computed
// expected bundle whenever its own occupancy model says an instruction is
// taken; a monitor on the falling edge compares the held bundle against the
// scoreboard head every cycle id_valid is high and pops it when consumed.
module tb_idu;

  typedef struct packed {
    logic [63:0] pc;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [1:0]  has_funct;
    logic        need_sext;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  flags;  // reg_wen, mem_ren, mem_wen, branch, jump, illegal
  } bnd_t;

  typedef struct {
    logic [31:0] inst;
    bnd_t        exp;
  } vec_t;

  localparam logic [5:0] RW = 6'b100000;
  localparam logic [5:0] MR = 6'b010000;
  localparam logic [5:0] MW = 6'b001000;
  localparam logic [5:0] BR = 6'b000100;
  localparam logic [5:0] JP = 6'b000010;
  localparam logic [5:0] IL = 6'b000001;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, ex_ready;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        if_ready, id_valid;
  logic [1:0]  alu_op, has_funct;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        need_sext, reg_wen, mem_ren, mem_wen, branch, jump, illegal;
  logic [63:0] imm, id_pc;
  logic [4:0]  rs1, rs2, rd;

  bnd_t act;
  bnd_t cur_exp;
  bnd_t sb[$];
  logic exp_full = 1'b0;
  logic accepted = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[16];

  always #5 clk = ~clk;

  idu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .flush(flush), .id_valid(id_valid),
    .ex_ready(ex_ready), .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
    .has_funct(has_funct), .need_sext(need_sext), .imm(imm), .rs1(rs1),
    .rs2(rs2), .rd(rd), .reg_wen(reg_wen), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .branch(branch), .jump(jump), .illegal(illegal),
    .id_pc(id_pc)
  );

  assign act = {id_pc, alu_op, funct3, funct7, has_funct, need_sext, imm,
                rs1, rs2, rd, reg_wen, mem_ren, mem_wen, branch, jump, illegal};

  task automatic check(input string name, input logic [255:0] got,
                       input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic bnd_t mk(input logic [1:0] a, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [1:0] hf,
                              input logic sx, input logic [63:0] im,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] rdi, input logic [5:0] fl);
    bnd_t b;
    b.pc = '0; b.alu_op = a; b.funct3 = f3; b.funct7 = f7; b.has_funct = hf;
    b.need_sext = sx; b.imm = im; b.rs1 = r1; b.rs2 = r2; b.rd = rdi;
    b.flags = fl;
    return b;
  endfunction

  // Occupancy model and scoreboard push, evaluated at each rising edge.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      sb.delete();
      exp_full = 1'b0;
      accepted = 1'b0;
    end else begin
      logic acc;
      acc      = if_valid && (!exp_full || ex_ready);
      accepted = acc && !flush;
      if (flush) begin
        // A held bundle that was not consumed this cycle is discarded.
        if (exp_full && !ex_ready) void'(sb.pop_front());
        exp_full = 1'b0;
      end else if (acc) begin
        sb.push_back(cur_exp);
        exp_full = 1'b1;
      end else if (ex_ready) begin
        exp_full = 1'b0;
      end
    end
  end

  // Monitor: sample away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("id_valid", id_valid, exp_full);
      check("if_ready", if_ready, !exp_full || ex_ready);
      if (id_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bundle: got %h expected none", act);
        end else begin
          check("bundle", act, sb[0]);
          if (ex_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic send(input int idx, input logic [63:0] pc);
    int n;
    if_inst    = vecs[idx].inst;
    if_pc      = pc;
    cur_exp    = vecs[idx].exp;
    cur_exp.pc = pc;
    if_valid   = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!accepted && n < 20);
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept after %0d cycles expected accept", n);
    end
    if_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h00500093, mk(2'b00, 3'd0, 7'h00, 2'b01, 1'b0, 64'd5, 5'd0, 5'd0, 5'd1, RW)};      // addi x1,x0,5
    vecs[1]  = '{32'h402081B3, mk(2'b10, 3'd0, 7'h20, 2'b11, 1'b0, 64'd0, 5'd1, 5'd2, 5'd3, RW)};      // sub x3,x1,x2
    vecs[2]  = '{32'hFE208EE3, mk(2'b11, 3'd0, 7'h00, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 5'd2, 5'd0, BR)}; // beq x1,x2,-4
    // inst[7]=0 here, so imm[11]=0 and the offset is -2052.
    vecs[3]  = '{32'hFE208E63, mk(2'b11, 3'd0, 7'h00, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_F7FC, 5'd1, 5'd2, 5'd0, BR)};
    vecs[4]  = '{32'h00813283, mk(2'b01, 3'd3, 7'h00, 2'b01, 1'b0, 64'd8, 5'd2, 5'd0, 5'd5, RW | MR)}; // ld x5,8(x2)
    vecs[5]  = '{32'hFE513C23, mk(2'b00, 3'd3, 7'h00, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 5'd2, 5'd5, 5'd0, MW)}; // sd x5,-8(x2)
    vecs[6]  = '{32'h800003B7, mk(2'b10, 3'd0, 7'h00, 2'b00, 1'b0, 64'hFFFF_FFFF_8000_0000, 5'd0, 5'd0, 5'd7, RW)}; // lui x7,0x80000
    vecs[7]  = '{32'h00001517, mk(2'b10, 3'd0, 7'h00, 2'b00, 1'b0, 64'h1000, 5'd0, 5'd0, 5'd10, RW)};  // auipc x10,1
    vecs[8]  = '{32'h008000EF, mk(2'b10, 3'd0, 7'h00, 2'b00, 1'b0, 64'd8, 5'd0, 5'd0, 5'd1, RW | JP)}; // jal x1,+8
    vecs[9]  = '{32'hFFDFF06F, mk(2'b10, 3'd0, 7'h00, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'd0, 5'd0, JP)}; // jal x0,-4
    vecs[10] = '{32'h004280E7, mk(2'b10, 3'd0, 7'h00, 2'b00, 1'b0, 64'd4, 5'd5, 5'd0, 5'd1, RW | JP)}; // jalr x1,4(x5)
    vecs[11] = '{32'h43F0D093, mk(2'b00, 3'd5, 7'h21, 2'b01, 1'b0, 64'h43F, 5'd1, 5'd0, 5'd1, RW)};   // srai x1,x1,63
    vecs[12] = '{32'h4032519B, mk(2'b00, 3'd5, 7'h20, 2'b01, 1'b1, 64'h403, 5'd4, 5'd0, 5'd3, RW)};   // sraiw x3,x4,3
    vecs[13] = '{32'h002081BB, mk(2'b10, 3'd0, 7'h00, 2'b11, 1'b1, 64'd0, 5'd1, 5'd2, 5'd3, RW)};     // addw x3,x1,x2
    vecs[14] = '{32'h00000013, mk(2'b00, 3'd0, 7'h00, 2'b01, 1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 6'b0)};   // nop
    vecs[15] = '{32'h00000000, mk(2'b00, 3'd0, 7'h00, 2'b00, 1'b0, 64'd0, 5'd0, 5'd0, 5'd0, IL)};     // illegal

    rst = 1'b1; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    if_inst = '0; if_pc = '0; cur_exp = '0;

    // Reset state.
    idle(2);
    check("reset_id_valid", id_valid, 1'b0);
    check("reset_if_ready", if_ready, 1'b1);
    check("reset_bundle", act, 164'd0);
    rst = 1'b0;

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < 16; i++) send(i, 64'hFFFF_FFFF_0000_0000 + 64'(4 * i));
    idle(2);

    // Backpressure: hold for three cycles with a new instruction offered.
    ex_ready = 1'b0;
    send(0, 64'h2000);
    if_inst = vecs[1].inst; if_pc = 64'h2004;
    cur_exp = vecs[1].exp;  cur_exp.pc = 64'h2004;
    if_valid = 1'b1;
    idle(3);
    ex_ready = 1'b1;
    idle(1);
    if_valid = 1'b0;
    idle(2);

    // Flush with a held bundle and a simultaneous offer.
    ex_ready = 1'b0;
    send(2, 64'h3000);
    if_inst = vecs[3].inst; if_pc = 64'h3004;
    cur_exp = vecs[3].exp;  cur_exp.pc = 64'h3004;
    if_valid = 1'b1; flush = 1'b1;
    idle(1);
    flush = 1'b0; if_valid = 1'b0;
    check("flush_id_valid", id_valid, 1'b0);
    ex_ready = 1'b1;
    idle(2);

    // Reset while a bundle is held.
    ex_ready = 1'b0;
    send(1, 64'h4000);
    rst = 1'b1;
    idle(1);
    check("midhold_id_valid", id_valid, 1'b0);
    check("midhold_if_ready", if_ready, 1'b1);
    check("midhold_bundle", act, 164'd0);
    rst = 1'b0; ex_ready = 1'b1;
    send(15, 64'h5000);
    send(0, 64'h5004);
    idle(3);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
